rf_wb_queue: RTL
================

// Module: rf_wb_queue
// PURPOSE
//  Write-side front end of the 32x32 register file: collects writeback requests from two
//  producers, the main pipeline (s0) and the long-latency mult/div unit (s1).
//  Requests are buffered in an in-order FIFO and drained one per cycle onto the register
//  file's single write port (wr_en/wr_addr/wr_data -> RFWr/A3/WD).
//  Removes write-port contention between producers without stalling either on collision.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  DW      32  data width
//  AW      5   register address width
// PORTS
//  clk       in   1    clock, all state on rising edge
//  rst       in   1    reset, asynchronous, active-high
//  s0_valid  in   1    pipeline writeback request
//  s0_addr   in   AW   destination register
//  s0_data   in   DW   writeback value
//  s0_ready  out  1    s0 request accepted this cycle if s0_valid
//  s1_valid  in   1    mult/div writeback request
//  s1_addr   in   AW   destination register
//  s1_data   in   DW   writeback value
//  s1_ready  out  1    s1 request accepted this cycle if s1_valid
//  drain_en  in   1    1 = head entry may be written to RF this cycle
//  wr_en     out  1    to RF RFWr
//  wr_addr   out  AW   to RF A3
//  wr_data   out  DW   to RF WD
//  count     out  clog2(DEPTH)+1  occupied entries
//  full      out  1    count==DEPTH
//  empty     out  1    count==0
// BEHAVIOUR
//  - Reset: all entries invalid; count=0, empty=1, full=0, wr_en=0, wr_addr=0, wr_data=0;
//    s0_ready=s1_ready=1 (DEPTH>=2).
//  - Handshake: transfer on valid&ready at the rising edge.
//  - Ready depends only on registered count, never on valid or on a same-cycle dequeue:
//    - s0_ready = (count<=DEPTH-1).
//    - s1_ready = (count<=DEPTH-2) | (count==DEPTH-1 & !s0_valid).
//  - Ordering: s0 has fixed priority. When both are accepted in one cycle, s0 is enqueued
//    ahead of s1.
//  - Address 0: request with addr==0 is accepted (ready as normal) but not stored; count unaffected.
//  - Dequeue: wr_en = !empty & drain_en. wr_addr/wr_data = head entry, 0 when empty.
//    Head pops at the edge where wr_en=1.
//  - Latency: request accepted at edge k -> wr_en at earliest in cycle k..k+1 -> RF written
//    at edge k+1. No combinational valid->wr_en path.
//  - Simultaneous enqueue(s)+dequeue: count_next = count + enq - deq.
//  - Full: pops free a slot for the following cycle only.
//  - Empty: no underflow; wr_en held 0.
//  - Pointers wrap modulo DEPTH.
//  - Duplicate addresses: both entries kept; writes reach RF in order, last write wins.
//  - rst asserted mid-operation discards all queued writes immediately. No partial RF write
//    issues after the rst edge.
// CONFIGURATION
//  - RF_WBQ_BYPASS_EN defined: adds inputs q_a1,q_a2 (AW) and outputs q_hit1,q_hit2 (1)
//    and q_rd1,q_rd2 (DW).
//    - q_hitN=1 when a queued entry matches q_aN!=0; q_rdN = data of youngest match.
//    - Purely combinational from queue state. Reset: hits 0, data 0.
//    - Lets decode read pending values before they drain.
//  - Undefined: these ports and all compare logic are absent.
// STRUCTURE
//  - Package rf_wbq_pkg: DW/AW constants and typedef wbq_entry_t {addr[AW-1:0], data[DW-1:0]}.
//  - Sub-module rf_wbq_fifo: 2-write/1-read circular buffer of wbq_entry_t with pointers
//    and count.
//  - Top holds arbitration, addr-0 filtering and optional bypass search.
// TESTING
//  1. Reset mid-traffic: 3 entries queued, pulse rst -> next cycle count=0, wr_en=0;
//     no stale writes appear later.
//  2. Single write: s0 {addr 5, 0xDEADBEEF}, drain_en=1 -> wr_en=1, wr_addr=5,
//     wr_data=0xDEADBEEF exactly one cycle; then empty=1.
//  3. Collision: s0 {3,0x11} + s1 {3,0x22} same cycle -> RF sees 0x11 then 0x22;
//     r3 ends 0x22.
//  4. Backpressure: drain_en=0, DEPTH=4, push 4 -> full=1, s0_ready=0.
//     Then count=3 and s0/s1 both valid -> only s0 accepted.
//     Release drain -> 4 writes in order.
//  5. Addr 0: s1 {0,0xFFFF} -> s1_ready=1, count unchanged, no wr_en.
//  6. Bypass (RF_WBQ_BYPASS_EN): drain_en=0, queue {7,0xA},{7,0xB}, q_a1=7 -> q_hit1=1,
//     q_rd1=0xB; q_a2=0 -> q_hit2=0.

Source files
------------

// File: rtl/rf_wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
//   DW          : writeback data width
//   AW          : register address width (32 registers)
//   wbq_entry_t : one queued write {addr, data}
package rf_wbq_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/rf_wbq_fifo.sv
// Circular buffer behind the writeback queue.
// It accepts up to two writes and one read per cycle.
// Write port 0 is always placed ahead of write port 1.
// The caller guarantees that the buffer never overflows or underflows.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   we0, wd0       : first (older) write
//   we1, wd1       : second (younger) write
//   re             : pop the head entry at this edge
//   head           : entry at the read pointer (meaningless when count==0)
//   count          : number of occupied entries
//   entries,rd_ptr : raw storage and read pointer, present only with
//                    RF_WBQ_BYPASS_EN defined (used by the bypass search)
module rf_wbq_fifo
    import rf_wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  wbq_entry_t               wd0,
    input  logic                     we1,
    input  wbq_entry_t               wd1,
    input  logic                     re,
    output wbq_entry_t               head,
`ifdef RF_WBQ_BYPASS_EN
    output wbq_entry_t [DEPTH-1:0]   entries,
    output logic [PW-1:0]            rd_ptr,
`endif
    output logic [CW-1:0]            count
);

    wbq_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [PW-1:0]          wptr_nxt1;
    logic [CW-1:0]          enq;

    // Pointers are PW bits wide, so they wrap modulo DEPTH because DEPTH is a power of two.
    assign wptr_nxt1 = wptr + PW'(1);
    assign enq       = CW'(we0) + CW'(we1);
    assign head      = mem[rptr];

`ifdef RF_WBQ_BYPASS_EN
    assign entries = mem;
    assign rd_ptr  = rptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(we0) + PW'(we1);
            rptr  <= rptr + PW'(re);
            count <= count + enq - CW'(re);
        end
    end

    // The storage needs no reset.
    // Occupancy is tracked only by count and the pointers.
    // If port 0 is idle, a lone port-1 write takes the first free slot.
    always_ff @(posedge clk) begin
        if (we0) mem[wptr] <= wd0;
        if (we1) mem[we0 ? wptr_nxt1 : wptr] <= wd1;
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue in front of the 32x32 register file's single write port.
// Two producers feed the queue: s0 is the main pipeline and has fixed
// priority, and s1 is the mult/div unit. Their requests are queued in
// order and drained one per cycle to the RF (wr_en/wr_addr/wr_data).
// Writes to r0 are accepted but dropped.
// DW/AW come from rf_wbq_pkg.
// Optional feature macro: RF_WBQ_BYPASS_EN. It adds a two-port lookup
// (q_a1/q_a2 -> q_hit*/q_rd*) that returns the youngest queued value for
// each address.
// Handshake: a request transfers at a rising edge where valid & ready.
// Ready is derived from the registered count and s0_valid only. It never
// depends on a same-cycle dequeue.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   s0_valid/addr/data/ready: pipeline writeback request
//   s1_valid/addr/data/ready: mult/div writeback request
//   drain_en                : allow the head entry to be written this cycle
//   wr_en, wr_addr, wr_data : RF write port (RFWr/A3/WD)
//   count, full, empty      : occupancy
module rf_wb_queue
    import rf_wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s0_valid,
    input  logic [AW-1:0]            s0_addr,
    input  logic [DW-1:0]            s0_data,
    output logic                     s0_ready,
    input  logic                     s1_valid,
    input  logic [AW-1:0]            s1_addr,
    input  logic [DW-1:0]            s1_data,
    output logic                     s1_ready,
    input  logic                     drain_en,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
`ifdef RF_WBQ_BYPASS_EN
    input  logic [AW-1:0]            q_a1,
    input  logic [AW-1:0]            q_a2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic [DW-1:0]            q_rd1,
    output logic [DW-1:0]            q_rd2,
`endif
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t head;
    wbq_entry_t s0_ent;
    wbq_entry_t s1_ent;
    logic       s0_push;
    logic       s1_push;

    // s1 may take the last free slot only when s0 is not competing for it.
    // This keeps the queue from overflowing even when a pop happens in the same cycle.
    assign s0_ready = (count <= CW'(DEPTH - 1));
    assign s1_ready = (count <= CW'(DEPTH - 2)) | ((count == CW'(DEPTH - 1)) & ~s0_valid);

    // A write to r0 completes the handshake but never occupies a slot.
    assign s0_push = s0_valid & s0_ready & (s0_addr != '0);
    assign s1_push = s1_valid & s1_ready & (s1_addr != '0);

    assign s0_ent = '{addr: s0_addr, data: s0_data};
    assign s1_ent = '{addr: s1_addr, data: s1_data};

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign wr_en   = ~empty & drain_en;
    assign wr_addr = empty ? '0 : head.addr;
    assign wr_data = empty ? '0 : head.data;

`ifdef RF_WBQ_BYPASS_EN
    wbq_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]          rd_ptr;

    // Entries are walked from oldest to youngest, so the last match is the youngest.
    function automatic logic [DW:0] bypass_lookup(
        input logic [AW-1:0]          a,
        input wbq_entry_t [DEPTH-1:0] ents,
        input logic [PW-1:0]          oldest,
        input logic [CW-1:0]          n
    );
        logic          hit;
        logic [DW-1:0] d;
        logic [PW-1:0] idx;
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = oldest + PW'(i);
            if ((a != '0) && (CW'(i) < n) && (ents[idx].addr == a)) begin
                hit = 1'b1;
                d   = ents[idx].data;
            end
        end
        return {hit, d};
    endfunction

    assign {q_hit1, q_rd1} = bypass_lookup(q_a1, entries, rd_ptr, count);
    assign {q_hit2, q_rd2} = bypass_lookup(q_a2, entries, rd_ptr, count);
`endif

    rf_wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .we0     (s0_push),
        .wd0     (s0_ent),
        .we1     (s1_push),
        .wd1     (s1_ent),
        .re      (wr_en),
        .head    (head),
`ifdef RF_WBQ_BYPASS_EN
        .entries (entries),
        .rd_ptr  (rd_ptr),
`endif
        .count   (count)
    );

endmodule
